// File: rtl/dds_tone_mc.sv
// Multi-channel DDS tone source for the WM8731 codec driver.
// Channels are time-multiplexed through one combinational cosine lookup, scaled
// by a per-channel gain, and committed as a frame behind a req/ack handshake.
// Optional build macro: DDS_DITHER_EN adds LFSR phase dither ahead of the lookup.
module dds_tone_mc #(
  parameter int unsigned p_channels = 2,
  parameter int unsigned p_phase_w  = 24,
  parameter int unsigned p_gain_w   = 8,
  parameter int unsigned p_divider  = 1000
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [p_channels-1:0]                i_en,
  input  logic [p_channels-1:0][p_phase_w-1:0] i_tune,
  input  logic [p_channels-1:0][p_gain_w-1:0]  i_gain,
  input  logic                                 i_ack,
  input  logic                                 i_ovf_clr,
  output logic [p_channels-1:0][15:0]          o_dat,
  output logic                                 o_req,
  output logic                                 o_ovf
);

  localparam int unsigned ChW   = (p_channels > 1) ? $clog2(p_channels) : 1;
  localparam int unsigned CntW  = $clog2(p_divider);
  localparam int unsigned ProdW = 16 + p_gain_w + 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLookup = 2'd1;
  localparam logic [1:0] StScale  = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  if (p_channels < 1 || p_channels > 8) begin : g_bad_channels
    $error("p_channels must be in 1..8");
  end
  if (p_phase_w < 16) begin : g_bad_phase_w
    $error("p_phase_w must be at least 16");
  end
  if (p_divider <= 2 * p_channels + 2) begin : g_bad_divider
    $error("p_divider must exceed 2*p_channels+2");
  end

  // Combinational cosine lookup: piecewise-linear stand-in that is exact at
  // 0 (+full scale), pi/2 (~0) and pi (-full scale, 16'h8000).
  function automatic logic signed [15:0] ram_cos(input logic [15:0] phase);
    logic [15:0]        fold;
    logic signed [17:0] lin;
    fold = phase[15] ? (~phase + 16'd1) : phase;
    lin  = 18'sd32767 - $signed({1'b0, fold, 1'b0});
    if (fold == 16'h8000) begin
      return 16'sh8000;
    end
    return lin[15:0];
  endfunction

  logic [CntW-1:0]                      cnt_q, cnt_d;
  logic                                 tick;
  logic [1:0]                           state_q, state_d;
  logic [ChW-1:0]                       ch_q, ch_d;
  logic signed [15:0]                   samp_q, samp_d;
  logic [p_channels-1:0][p_phase_w-1:0] acc_q, acc_d;
  logic [p_channels-1:0][15:0]          sh_q, sh_d;
  logic [p_channels-1:0][15:0]          dat_q, dat_d;
  logic                                 req_q, req_d;
  logic                                 ovf_q, ovf_d;
  logic [p_phase_w-1:0]                 phase_sel;
  logic signed [ProdW-1:0]              prod;
  logic signed [ProdW-1:0]              prod_sh;

`ifdef DDS_DITHER_EN
  logic [15:0]          lfsr_q, lfsr_d;
  logic [p_phase_w-1:0] dith;

  // Galois LFSR x^16+x^14+x^13+x^11+1, stepped once per lookup
  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == StLookup) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  // Dither only reaches the bits that truncation would otherwise discard
  always_comb begin
    dith = '0;
    for (int b = 0; b < 16; b++) begin
      if (b < int'(p_phase_w) - 16) begin
        dith[b] = lfsr_q[b];
      end
    end
  end

  // Seeded non-zero: an all-zero Galois LFSR never leaves zero
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

  // Lookup phase: accumulator (plus dither when built in); accumulator itself untouched
  always_comb begin
`ifdef DDS_DITHER_EN
    phase_sel = acc_q[ch_q] + dith;
`else
    phase_sel = acc_q[ch_q];
`endif
  end

  // Gain scaling: signed multiply by zero-extended gain, floor via arithmetic shift
  always_comb begin
    prod    = ProdW'(samp_q) * $signed({1'b0, i_gain[ch_q]});
    prod_sh = prod >>> p_gain_w;
  end

  // Sample-rate divider
  always_comb begin
    tick  = (cnt_q == CntW'(p_divider - 1));
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  // Channel sequencer, frame commit and handshake
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    samp_d  = samp_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    dat_d   = dat_q;
    req_d   = req_q;
    ovf_d   = ovf_q;

    if (req_q && i_ack) begin
      req_d = 1'b0;
    end
    if (i_ovf_clr) begin
      ovf_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StLookup;
          ch_d    = '0;
        end
      end
      StLookup: begin
        samp_d  = ram_cos(phase_sel[p_phase_w-1 -: 16]);
        state_d = StScale;
      end
      StScale: begin
        // Sample uses the pre-increment phase; disabled channels hold phase
        if (i_en[ch_q]) begin
          sh_d[ch_q]  = prod_sh[15:0];
          acc_d[ch_q] = acc_q[ch_q] + i_tune[ch_q];
        end else begin
          sh_d[ch_q] = '0;
        end
        if (ch_q == ChW'(p_channels - 1)) begin
          state_d = StDone;
        end else begin
          ch_d    = ch_q + ChW'(1);
          state_d = StLookup;
        end
      end
      StDone: begin
        // Commit wins over a same-cycle ack; an unconsumed frame drops the new one
        if (!req_q || i_ack) begin
          dat_d = sh_q;
          req_d = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any frame in flight
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q   <= '0;
      state_q <= StIdle;
      ch_q    <= '0;
      samp_q  <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      dat_q   <= '0;
      req_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      ch_q    <= ch_d;
      samp_q  <= samp_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      dat_q   <= dat_d;
      req_q   <= req_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_dat = dat_q;
  assign o_req = req_q;
  assign o_ovf = ovf_q;

endmodule

// File: tb/tb_dds_tone_mc.sv
// Scoreboard bench for dds_tone_mc (2 channels, divider 16, 24-bit phase, 8-bit gain).
// Stimulus pushes one expected frame per sample period; a monitor pops on each
// transfer (o_req && i_ack) and compares o_dat.
module tb_dds_tone_mc;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        en;
  logic [1:0][23:0]  tune;
  logic [1:0][7:0]   gain;
  logic              ack;
  logic              ovf_clr;
  logic [1:0][15:0]  o_dat;
  logic              o_req;
  logic              o_ovf;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [23:0] ph [2];
  logic [31:0] exp_q [$];

  dds_tone_mc #(
    .p_channels(2),
    .p_phase_w (24),
    .p_gain_w  (8),
    .p_divider (16)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (en),
    .i_tune   (tune),
    .i_gain   (gain),
    .i_ack    (ack),
    .i_ovf_clr(ovf_clr),
    .o_dat    (o_dat),
    .o_req    (o_req),
    .o_ovf    (o_ovf)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; the DUT tick counter equals cyc mod 16
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference cosine: triangle through +32767 at 0 and -32768 at half turn
  function automatic int cos_ref(input int idx);
    int d;
    int v;
    d = (idx <= 32768) ? idx : 65536 - idx;
    v = 32767 - 2 * d;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  function automatic logic [15:0] scale_ref(input int s, input int g);
    int p;
    p = s * g;
    return 16'(p >>> 8);
  endfunction

  // Model one sample period using the current inputs; optionally expect a transfer
  task automatic push_frame(input bit do_push);
    logic [31:0] f;
    f = '0;
    for (int c = 0; c < 2; c++) begin
      if (en[c]) begin
        f[c*16 +: 16] = scale_ref(cos_ref(int'(ph[c][23:8])), int'(gain[c]));
        ph[c] = ph[c] + tune[c];
      end
    end
    if (do_push) exp_q.push_back(f);
  endtask

  task automatic to_slot(input int s);
    do begin
      @(posedge clk);
      #1;
    end while (cyc % 16 != s);
  endtask

  task automatic frame(input bit do_push);
    push_frame(do_push);
    to_slot(8);
  endtask

  // Reset, release, check first-frame latency, end aligned on slot 8
  task automatic restart();
    int n;
    rst = 1'b1;
    ph[0] = '0;
    ph[1] = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    push_frame(1'b1);
    n = 0;
    while (!o_req && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("first_req_cycle", 32'(cyc), 32'd21);
    to_slot(8);
  endtask

  // Monitor: every accepted frame is compared against the scoreboard head
  always @(negedge clk) begin
    if (!rst && o_req && ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL xfer_unexpected: got %h expected none", o_dat);
      end else begin
        check("xfer", o_dat, exp_q.pop_front());
      end
    end
  end

  initial begin
    en      = 2'b11;
    tune    = '0;
    gain    = {8'hFF, 8'hFF};
    ack     = 1'b1;
    ovf_clr = 1'b0;
    ph[0]   = '0;
    ph[1]   = '0;

    // Reset state
    #12;
    check("rst_dat", o_dat, 32'h0);
    check("rst_req", 32'(o_req), 32'h0);
    check("rst_ovf", 32'(o_ovf), 32'h0);

    // 1: zero tuning, unity gain
    restart();
    check("case1_dat", o_dat, 32'h7F7F_7F7F);
    repeat (3) frame(1'b1);

    // 2: tuning and accumulator wrap (FF0000 + 020000 -> 010000)
    tune[0] = 24'h010000;
    tune[1] = 24'hFF0000;
    frame(1'b1);
    tune[1] = 24'h020000;
    repeat (4) frame(1'b1);

    // 3: ack low across three ticks -> overrun, first frame kept
    ack = 1'b0;
    frame(1'b1);
    check("ovr_req_a", 32'(o_req), 32'h1);
    check("ovr_ovf_a", 32'(o_ovf), 32'h0);
    frame(1'b0);
    check("ovr_ovf_b", 32'(o_ovf), 32'h1);
    frame(1'b0);
    check("ovr_ovf_c", 32'(o_ovf), 32'h1);
    ack = 1'b1;
    push_frame(1'b1);
    @(posedge clk);
    #1;
    check("ovr_req_drop", 32'(o_req), 32'h0);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(o_ovf), 32'h0);
    to_slot(8);
    frame(1'b1);

    // 4: ack coincident with DONE while o_req is high
    ack = 1'b0;
    frame(1'b1);
    check("ackdone_req_pre", 32'(o_req), 32'h1);
    push_frame(1'b1);
    to_slot(4);
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
    check("ackdone_req", 32'(o_req), 32'h1);
    check("ackdone_ovf", 32'(o_ovf), 32'h0);
    to_slot(8);
    ack = 1'b1;
    frame(1'b1);

    // 6: reset during channel 1 lookup with a pending frame and overrun set
    ack = 1'b0;
    frame(1'b0);
    frame(1'b0);
    check("prerst_req", 32'(o_req), 32'h1);
    check("prerst_ovf", 32'(o_ovf), 32'h1);
    push_frame(1'b0);
    to_slot(2);
    rst = 1'b1;
    #1;
    check("midrst_dat", o_dat, 32'h0);
    check("midrst_req", 32'(o_req), 32'h0);
    check("midrst_ovf", 32'(o_ovf), 32'h0);
    tune = '0;
    gain = {8'hFF, 8'hFF};
    en   = 2'b11;
    ack  = 1'b1;
    restart();
    check("restart_dat", o_dat, 32'h7F7F_7F7F);
    frame(1'b1);

    // 5: channel 1 disabled, half gain on channel 0, half-turn tuning
    en      = 2'b01;
    gain[0] = 8'h80;
    tune[0] = 24'h800000;
    tune[1] = 24'h020000;
    frame(1'b1);
    check("half_gain_dat", o_dat, 32'h0000_3FFF);
    frame(1'b1);
    check("neg_full_dat", o_dat, 32'h0000_C000);
    en = 2'b11;
    frame(1'b1);
    check("frozen_ch1_dat", o_dat, 32'h7F7F_3FFF);
    repeat (2) frame(1'b1);

    // Drain scoreboard
    for (int i = 0; i < 64; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    check("drain", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
